// File: rtl/noc_out_arbiter_if.sv
// rtl/noc_out_arbiter_if.sv - FIFO-side pop handshake and registered valid/ready output link of the output arbiter
interface noc_out_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 33
);
  logic [NUM_IN-1:0]        in_empty;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_rd_en;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  in_empty, in_data, out_ready,
    output in_rd_en, out_data, out_valid
  );

  modport slave (
    output in_empty, in_data, out_ready,
    input  in_rd_en, out_data, out_valid
  );
endinterface

// File: rtl/noc_out_arbiter.sv
// rtl/noc_out_arbiter.sv - packet-locked round-robin output scheduler for a NoC router port
// Optional stall watchdog enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_out_arbiter #(
  parameter int NUM_IN   = 4,
  parameter int DATA_W   = 33,
  parameter int WDOG_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  noc_out_arbiter_if.master  bus,
  output logic [NUM_IN-1:0]  grant,
  output logic               busy,
  output logic               wdog_err
);
  localparam int PTR_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   lock_id;
  logic               can_load;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   pop_idx;
  logic               pop_en;
  logic [DATA_W-1:0]  pop_flit;
  logic               pop_tail;
  logic               wdog_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_IN - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NUM_IN-1:0] onehot(input logic [PTR_W-1:0] p);
    logic [NUM_IN-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Returns {found, index}; scanning offsets high-to-low lets the lowest offset win.
  function automatic logic [PTR_W:0] pick(input logic [NUM_IN-1:0] empty,
                                          input logic [PTR_W-1:0]  ptr);
    logic [PTR_W:0] r;
    int             idx;
    r = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_IN;
      if (!empty[idx]) r = {1'b1, PTR_W'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    can_load      = !bus.out_valid || bus.out_ready;
    {found, winner} = pick(bus.in_empty, rr_ptr);
    pop_idx       = (state == LOCK) ? lock_id : winner;
    pop_en        = !rst && can_load &&
                    ((state == LOCK) ? !bus.in_empty[lock_id] : found);
    pop_flit      = bus.in_data[int'(pop_idx)*DATA_W +: DATA_W];
    pop_tail      = pop_flit[DATA_W-1];
    bus.in_rd_en  = pop_en ? onehot(pop_idx) : '0;
  end

  assign busy = (state == LOCK) || bus.out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      lock_id       <= '0;
      grant         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (pop_en) begin
        bus.out_data  <= pop_flit;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop_en) begin
            if (pop_tail) begin
              rr_ptr <= ptr_inc(winner);
            end else begin
              state   <= LOCK;
              lock_id <= winner;
              grant   <= onehot(winner);
            end
          end
        end
        LOCK: begin
          // A watchdog abort releases the lock exactly like a tail would.
          if ((pop_en && pop_tail) || wdog_fire) begin
            state  <= IDLE;
            rr_ptr <= ptr_inc(lock_id);
            grant  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall limits below one cycle are meaningless; nothing here for such builds.
  if (WDOG_CYC < 1) begin : g_wdog_cyc_invalid
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Fires on the stalled cycle that brings the count to WDOG_CYC.
  assign wdog_fire = (state == LOCK) && bus.in_empty[lock_id] &&
                     (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state != LOCK || pop_en || wdog_fire) begin
        wdog_cnt <= '0;
      end else if (bus.in_empty[lock_id]) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_fire) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif
endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb/tb_noc_out_arbiter.sv - scoreboard bench for noc_out_arbiter with a packet-level round-robin model
module tb_noc_out_arbiter;
  localparam int NUM_IN   = 4;
  localparam int DATA_W   = 33;
  localparam int WDOG_CYC = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_IN-1:0] grant;
  logic              busy;
  logic              wdog_err;

  noc_out_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) ifc ();

  noc_out_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .WDOG_CYC(WDOG_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc.master),
    .grant    (grant),
    .busy     (busy),
    .wdog_err (wdog_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fq [NUM_IN][$];   // contents of the upstream FIFOs
  logic [DATA_W-1:0] mp [NUM_IN][$];   // flits the model has yet to schedule
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] held_tail;
  int                n_vec = 0;
  int                n_bad = 0;
  bit                sb_en = 1'b0;
  int                cyc = 0;
  int                model_ptr = 0;
  int                uid = 0;
  logic [NUM_IN-1:0] last_pop, last_grant;
  logic              last_valid, last_busy, last_wdog;
  logic [DATA_W-1:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NUM_IN; i++) begin
      ifc.in_empty[i] = (fq[i].size() == 0);
      ifc.in_data[i*DATA_W +: DATA_W] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  // One clock: sample at the falling edge, then act as the FIFOs just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    last_pop   = ifc.in_rd_en;
    last_grant = grant;
    last_valid = ifc.out_valid;
    last_busy  = busy;
    last_wdog  = wdog_err;
    last_data  = ifc.out_data;
    check("rd_en_onehot0", 64'($onehot0(last_pop)), 64'd1);
    for (int i = 0; i < NUM_IN; i++)
      if (last_pop[i] && fq[i].size() == 0) check("pop_of_empty_fifo", 64'(i), 64'hffff);
`ifndef NOC_ARB_WATCHDOG_EN
    check("wdog_tied_low", 64'(wdog_err), 64'd0);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_IN; i++)
      if (last_pop[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    drive_fifos();
  endtask

  task automatic load(input int port, input int len, input bit hold_tail, input bit to_model);
    logic [DATA_W-1:0] f;
    for (int k = 0; k < len; k++) begin
      uid++;
      f = {(k == len - 1), 8'(port), 24'(uid)};
      if (to_model) mp[port].push_back(f);
      if (hold_tail && k == len - 1) held_tail = f;
      else fq[port].push_back(f);
    end
    drive_fifos();
  endtask

  // Whole packets in round-robin order; the pointer moves past a port only after its packet.
  task automatic predict();
    logic [DATA_W-1:0] f;
    int p;
    bit any;
    forever begin
      any = 1'b0;
      p = 0;
      for (int off = NUM_IN - 1; off >= 0; off--)
        if (mp[(model_ptr + off) % NUM_IN].size() != 0) begin
          p = (model_ptr + off) % NUM_IN;
          any = 1'b1;
        end
      if (!any) break;
      do begin
        f = mp[p].pop_front();
        exp_q.push_back(f);
      end while (!f[DATA_W-1]);
      model_ptr = (p + 1) % NUM_IN;
    end
  endtask

  task automatic drain(input int limit, input bit rnd_ready);
    int n;
    bit pending;
    n = 0;
    forever begin
      pending = (exp_q.size() != 0) || ifc.out_valid;
      for (int i = 0; i < NUM_IN; i++) if (fq[i].size() != 0) pending = 1'b1;
      if (!pending || n >= limit) break;
      ifc.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    ifc.out_ready = 1'b1;
    check("drain_within_budget", 64'(n < limit), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && sb_en && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flit", 64'(ifc.out_data), 64'hdead);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_flit", 64'(ifc.out_data), 64'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    logic [DATA_W-1:0] hold;
    rst = 1'b1;
    ifc.out_ready = 1'b1;
    fq[0].push_back({1'b1, 32'h0000_00aa});
    drive_fifos();
    step();
    step();
    check("rst_rd_en", 64'(last_pop), 64'd0);
    check("rst_out_valid", 64'(last_valid), 64'd0);
    check("rst_out_data", 64'(last_data), 64'd0);
    check("rst_grant", 64'(last_grant), 64'd0);
    check("rst_busy", 64'(last_busy), 64'd0);
    check("rst_wdog_err", 64'(last_wdog), 64'd0);
    fq[0].delete();
    drive_fifos();
    rst = 1'b0;
    sb_en = 1'b1;

    // Three-flit packet on port 0.
    load(0, 3, 1'b0, 1'b1);
    predict();
    step(); check("t1_a_rd_en", 64'(last_pop), 64'h1); check("t1_a_grant", 64'(last_grant), 64'h0);
    step(); check("t1_b_rd_en", 64'(last_pop), 64'h1); check("t1_b_grant", 64'(last_grant), 64'h1);
    check("t1_b_valid", 64'(last_valid), 64'd1);
    step(); check("t1_c_rd_en", 64'(last_pop), 64'h1); check("t1_c_grant", 64'(last_grant), 64'h1);
    step(); check("t1_d_rd_en", 64'(last_pop), 64'h0); check("t1_d_grant", 64'(last_grant), 64'h0);
    check("t1_d_valid", 64'(last_valid), 64'd1); check("t1_d_busy", 64'(last_busy), 64'd1);
    step(); check("t1_e_valid", 64'(last_valid), 64'd0); check("t1_e_busy", 64'(last_busy), 64'd0);
    drain(50, 1'b0);

    // Port 1 locked with a late tail while port 2 waits.
    load(1, 2, 1'b1, 1'b1);
    load(2, 2, 1'b0, 1'b1);
    predict();
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_port2_blocked", 64'(last_pop[2]), 64'd0);
    end
    fq[1].push_back(held_tail);
    drive_fifos();
    step(); check("t3_tail_pop", 64'(last_pop), 64'h2);
    step(); check("t3_port2_next", 64'(last_pop), 64'h4);
    drain(50, 1'b0);

    // Reset in the middle of a packet drops lock and output.
    sb_en = 1'b0;
    load(0, 3, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step(); check("t5_rd_en_in_rst", 64'(last_pop), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < NUM_IN; i++) fq[i].delete();
    drive_fifos();
    step();
    check("t5_valid", 64'(last_valid), 64'd0);
    check("t5_grant", 64'(last_grant), 64'd0);
    check("t5_rd_en", 64'(last_pop), 64'd0);
    model_ptr = 0;
    sb_en = 1'b1;

    // Four single-flit packets: one per cycle in port order from pointer 0.
    for (int p = 0; p < NUM_IN; p++) load(p, 1, 1'b0, 1'b1);
    predict();
    for (int p = 0; p < NUM_IN; p++) begin
      step();
      check("t2_rr_order", 64'(last_pop), 64'(1 << p));
    end
    drain(50, 1'b0);

    // Backpressure mid-packet.
    load(2, 4, 1'b0, 1'b1);
    predict();
    step();
    step();
    ifc.out_ready = 1'b0;
    hold = ifc.out_data;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_no_pop", 64'(last_pop), 64'h0);
      check("t4_valid_held", 64'(last_valid), 64'd1);
      check("t4_data_held", 64'(last_data), 64'(hold));
    end
    drain(50, 1'b0);

`ifdef NOC_ARB_WATCHDOG_EN
    sb_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    fq[0].push_back({1'b0, 32'h0000_0b0d});
    fq[1].push_back({1'b1, 32'h0000_0b1e});
    drive_fifos();
    step(); check("t6_lock_pop", 64'(last_pop), 64'h1);
    for (int k = 0; k < WDOG_CYC; k++) begin
      step();
      check("t6_stall_no_pop", 64'(last_pop), 64'h0);
      check("t6_err_not_yet", 64'(last_wdog), 64'd0);
    end
    step();
    check("t6_wdog_err", 64'(last_wdog), 64'd1);
    check("t6_grant_released", 64'(last_grant), 64'h0);
    check("t6_port1_popped", 64'(last_pop), 64'h2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_err_sticky", 64'(last_wdog), 64'd1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("t6_err_cleared", 64'(last_wdog), 64'd0);
    model_ptr = 0;
    sb_en = 1'b1;
`endif

    // Randomized batches with random downstream stalls.
    for (int ph = 0; ph < 40; ph++) begin
      for (int p = 0; p < NUM_IN; p++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int k = 0; k < npk; k++) load(p, $urandom_range(1, 4), 1'b0, 1'b1);
      end
      predict();
      drain(400, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Output-port scheduler for a NoC router.
- Shares one output link between NUM_IN input FIFOs (33-bit flits, bit 32 = tail flag) using packet-locked round-robin arbitration.
- Pops the winning FIFO and registers the flit onto a valid/ready output.
- Sits between the per-input FIFOs and the link/crossbar stage.

Parameters:
NUM_IN, 4, number of input FIFOs; at least 2; rr_ptr width is clog2(NUM_IN)
DATA_W, 33, flit width; bit DATA_W-1 is the tail flag
WDOG_CYC, 64, stall limit in cycles for the optional watchdog

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
in_empty  in  NUM_IN  per-FIFO empty flag
in_data  in  NUM_IN*DATA_W  FIFO head flits, first-word-fall-through; port i at [i*DATA_W +: DATA_W]; valid whenever in_empty[i]=0
in_rd_en  out  NUM_IN  per-FIFO pop; combinational, at most one bit high
out_data  out  DATA_W  registered output flit
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data when out_valid & out_ready
grant  out  NUM_IN  one-hot port currently locked mid-packet; 0 when unlocked
busy  out  1  state==LOCK or out_valid
wdog_err  out  1  sticky watchdog error

Behaviour:
- Reset (synchronous, active-high, while rst=1):
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, grant=0, wdog_err=0.
  - in_rd_en is forced to 0.
- can_load = !out_valid | out_ready. Combinational ready path; single output register.
- Pop rule:
  - in_rd_en[k]=1 only when can_load=1 and in_empty[k]=0.
  - A pop in cycle t loads out_data <= in_data[k] and out_valid <= 1 at the end of cycle t.
  - Pop-to-output latency is 1 cycle.
  - Throughput is 1 flit/cycle while out_ready=1.
- When out_valid & out_ready with no load: out_valid <= 0 and out_data holds its value.
- While out_valid & !out_ready: out_data and out_valid are held stable and no pop occurs.
- IDLE state:
  - winner = first k with in_empty[k]=0, searching rr_ptr, rr_ptr+1, ... modulo NUM_IN.
  - If a winner exists and can_load=1: pop the winner.
  - If the popped flit is a tail: stay in IDLE and set rr_ptr <= winner+1 mod NUM_IN. This handles single-flit packets.
  - Otherwise: go to LOCK with lock_id <= winner.
  - grant=0 in IDLE.
- LOCK state:
  - grant = onehot(lock_id).
  - Only lock_id is eligible; all other requests are ignored.
  - Pop when in_empty[lock_id]=0 and can_load=1.
  - Tail popped -> IDLE with rr_ptr <= lock_id+1 mod NUM_IN.
  - Empty lock_id -> wait in LOCK. No bubble insertion is needed for correctness.
- Back-to-back packets:
  - The tail pop transitions to IDLE.
  - The next cycle arbitrates with the updated rr_ptr.
  - Consecutive packets from different ports are separated by zero idle output cycles when out_ready=1.
- Fairness: rr_ptr advances only on tail, so each port gets at most one packet per round.
- Reset mid-packet:
  - Lock and output flit are dropped.
  - Remaining body flits in the FIFO are treated as a new packet; upstream flushes on reset.

Optional Feature:
Macro NOC_ARB_WATCHDOG_EN.
- Defined:
  - Counter wdog_cnt (clog2(WDOG_CYC+1) bits) increments each LOCK cycle with in_empty[lock_id]=1.
  - Cleared on any pop, on leaving LOCK, and on rst.
  - When wdog_cnt reaches WDOG_CYC: wdog_err <= 1 (sticky until rst), state -> IDLE, rr_ptr <= lock_id+1 mod NUM_IN, counter cleared.
  - out_valid/out_data are unaffected.
- Undefined:
  - No counter; wdog_err is tied to 0.
  - Lock is held indefinitely until the tail arrives.

Test Plan:
1. Reset then port0 holds 3-flit packet (tail on 3rd), out_ready=1 -> in_rd_en=0001 for 3 consecutive cycles; out_valid high for 3 cycles carrying flits in order; grant=0001 for the first 2 flits, then 0 with state IDLE; rr_ptr=1.
2. All 4 ports hold single-flit packets, out_ready=1 -> outputs in order port0,1,2,3 on 4 consecutive cycles; no gaps.
3. Port1 locked with 2-flit packet while port2 requests; port1's tail arrives 5 cycles late -> port2 is never popped until port1's tail is popped; port2's first flit appears the cycle after port1's tail.
4. Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data stable, in_rd_en=0 throughout; on out_ready=1 flow resumes with no flit lost or duplicated.
5. rst=1 asserted mid-packet for 1 cycle -> next cycle out_valid=0, grant=0, rr_ptr=0, in_rd_en=0.
6. With NOC_ARB_WATCHDOG_EN and WDOG_CYC=8: port0 locked, then in_empty[0]=1 for 8 cycles -> wdog_err=1 (sticky); grant=0; port1's pending flit is popped on the following cycle.
